// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path: default frame geometry and
// the bit layout of a buffered frame entry {stp_err, par_err, data}.
package uart_rx_pkg;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DROP_CNT_W    = 8;
  localparam int ENTRY_PAR_BIT = DEF_WIDTH;
  localparam int ENTRY_STP_BIT = DEF_WIDTH + 1;

  function automatic int entry_w(input int width);
    return width + 2;
  endfunction
endpackage

// File: rtl/uart_rx_frame_fifo_if.sv
// Head-of-FIFO valid/ready stream: the FIFO is master, the consumer is slave.
interface uart_rx_frame_fifo_if #(parameter int Width = 8);
  logic [Width-1:0] OUT_DATA;
  logic             OUT_PAR_ERR;
  logic             OUT_STP_ERR;
  logic             OUT_VALID;
  logic             OUT_READY;

  modport master (output OUT_DATA, OUT_PAR_ERR, OUT_STP_ERR, OUT_VALID, input OUT_READY);
  modport slave  (input OUT_DATA, OUT_PAR_ERR, OUT_STP_ERR, OUT_VALID, output OUT_READY);
endinterface

// File: rtl/uart_rx_fifo_mem.sv
// Frame storage: one synchronous write port, one combinational read port, no reset.
module uart_rx_fifo_mem #(
  parameter int EntW  = 10,
  parameter int Depth = 16,
  localparam int AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [EntW-1:0]  wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [EntW-1:0]  rdata
);
  logic [Depth-1:0][EntW-1:0] mem;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_frame_fifo.sv
// Captures UART receiver frames on the data-valid rising edge into a FWFT FIFO,
// with optional error-frame dropping, sticky overflow and a saturating drop count.
module uart_rx_frame_fifo
  import uart_rx_pkg::*;
#(
  parameter int Width = DEF_WIDTH,
  parameter int Depth = DEF_DEPTH,
  localparam int AddrW = $clog2(Depth)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [Width-1:0]      RX_P_DATA,
  input  logic                  RX_DATA_VALID,
  input  logic                  RX_PAR_ERR,
  input  logic                  RX_STP_ERR,
  input  logic                  DROP_ERR_FRAMES,
  uart_rx_frame_fifo_if.master  out,
  output logic [AddrW:0]        FIFO_COUNT,
  output logic                  FULL,
  output logic                  OVERFLOW,
  input  logic                  CLR_OVERFLOW,
  output logic [DROP_CNT_W-1:0] DROP_COUNT
);
  localparam int EntW = entry_w(Width);
  localparam logic [AddrW:0] DepthC = AddrW'(0) + (AddrW+1)'(Depth);

  logic                  dv_q;
  logic [AddrW-1:0]      rd_ptr, wr_ptr;
  logic [AddrW:0]        count_q, count_nxt;
  logic                  valid_q, full_q, ovf_q;
  logic [DROP_CNT_W-1:0] drop_q;
  logic [EntW-1:0]       rdata;

  logic rise, drop, push_req, push_ok, pop, ovf_set;

  assign rise     = RX_DATA_VALID & ~dv_q;
  assign drop     = rise & DROP_ERR_FRAMES & (RX_PAR_ERR | RX_STP_ERR);
  assign push_req = rise & ~drop;
  assign pop      = valid_q & out.OUT_READY;
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign push_ok  = push_req & (~full_q | pop);
  assign ovf_set  = push_req & full_q & ~pop;

  always_comb begin
    count_nxt = count_q;
    case ({push_ok, pop})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      // dv_q starts high so a level already asserted at release is not a new frame.
      dv_q    <= 1'b1;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      dv_q    <= RX_DATA_VALID;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
      valid_q <= (count_nxt != '0);
      full_q  <= (count_nxt == DepthC);
      if (ovf_set)           ovf_q <= 1'b1;
      else if (CLR_OVERFLOW) ovf_q <= 1'b0;
      if (drop && drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end

  uart_rx_fifo_mem #(.EntW(EntW), .Depth(Depth)) u_mem (
    .clk   (CLK),
    .we    (push_ok & ~RST),
    .waddr (wr_ptr),
    .wdata ({RX_STP_ERR, RX_PAR_ERR, RX_P_DATA}),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign out.OUT_DATA    = rdata[Width-1:0];
  assign out.OUT_PAR_ERR = rdata[Width];
  assign out.OUT_STP_ERR = rdata[Width+1];
  assign out.OUT_VALID   = valid_q;
  assign FIFO_COUNT      = count_q;
  assign FULL            = full_q;
  assign OVERFLOW        = ovf_q;
  assign DROP_COUNT      = drop_q;
endmodule
